// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard bus: read ports, issue handshake and write-back.
interface regfile_scoreboard_if;
  logic [5:0]  ra1;
  logic [5:0]  ra2;
  logic        hilo_sel;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        issue_valid;
  logic [5:0]  issue_wa;
  logic        stall;
  logic        wb_valid;
  logic [5:0]  wb_wa;
  logic [31:0] wb_data;
  logic [31:0] wb_data_hi;
  logic        wb_err;

  // Pipeline side: drives addresses, issue requests and write-backs
  modport master (
    output ra1, ra2, hilo_sel, issue_valid, issue_wa,
           wb_valid, wb_wa, wb_data, wb_data_hi,
    input  rd1, rd2, stall, wb_err
  );

  // Register file side
  modport slave (
    input  ra1, ra2, hilo_sel, issue_valid, issue_wa,
           wb_valid, wb_wa, wb_data, wb_data_hi,
    output rd1, rd2, stall, wb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file (GPR 1..31 plus HI/LO at address 33) with a per-register
// pending-write scoreboard that stalls issue on RAW hazards and on a full
// destination counter. Reads are combinational with write-through bypass.
module regfile_scoreboard #(
  parameter int MAX_PEND = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_scoreboard_if.slave bus
);

  localparam int CW = (MAX_PEND < 2) ? 1 : $clog2(MAX_PEND + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_PEND);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [5:0]    HILO_ADDR = 6'd33;

  // Tracked addresses: 1..31 and 33. Everything else reads 0 and is ignored.
  function automatic logic is_tracked(input logic [5:0] a);
    return ((a != 6'd0) && (a < 6'd32)) || (a == HILO_ADDR);
  endfunction

  // Counter slot: GPRs use their own index, HI/LO reuses the unused slot 0.
  function automatic logic [4:0] slot_of(input logic [5:0] a);
    return (a == HILO_ADDR) ? 5'd0 : a[4:0];
  endfunction

  // Architectural state
  logic [31:0]   gpr_q [0:31];
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [CW-1:0] cnt_q [0:31];
  logic [CW-1:0] cnt_d [0:31];
  logic          wb_err_q;
  logic          wb_err_d;

  // Decoded write-back and issue information
  logic          wb_trk;
  logic [4:0]    wb_slot;
  logic [CW-1:0] wb_cnt;
  logic          iss_trk;
  logic [4:0]    iss_slot;
  logic [CW-1:0] iss_cnt;
  logic          wb_to_iss;
  logic          dest_full;
  logic          accept;

  assign wb_trk    = bus.wb_valid && is_tracked(bus.wb_wa);
  assign wb_slot   = slot_of(bus.wb_wa);
  assign wb_cnt    = cnt_q[wb_slot];
  assign iss_trk   = is_tracked(bus.issue_wa);
  assign iss_slot  = slot_of(bus.issue_wa);
  assign iss_cnt   = cnt_q[iss_slot];
  assign wb_to_iss = bus.wb_valid && (bus.wb_wa == bus.issue_wa);

  // A source is pending unless its last outstanding write retires this cycle
  logic [CW-1:0] c1;
  logic [CW-1:0] c2;
  logic          pend1;
  logic          pend2;

  assign c1    = cnt_q[slot_of(bus.ra1)];
  assign c2    = cnt_q[slot_of(bus.ra2)];
  assign pend1 = is_tracked(bus.ra1) && (c1 != CNT_ZERO) &&
                 !(bus.wb_valid && (bus.wb_wa == bus.ra1) && (c1 == CNT_ONE));
  assign pend2 = is_tracked(bus.ra2) && (c2 != CNT_ZERO) &&
                 !(bus.wb_valid && (bus.wb_wa == bus.ra2) && (c2 == CNT_ONE));

  // A full destination counter only blocks if no write-back frees a slot now
  assign dest_full = iss_trk && (iss_cnt == CNT_MAX) && !wb_to_iss;

  logic stall_c;
  assign stall_c   = bus.issue_valid && (pend1 || pend2 || dest_full);
  assign accept    = bus.issue_valid && !stall_c && iss_trk;
  assign bus.stall = stall_c;

  // Write-back to an address with nothing outstanding is flagged until reset
  assign wb_err_d   = wb_err_q || (wb_trk && (wb_cnt == CNT_ZERO));
  assign bus.wb_err = wb_err_q;

  // Read port 1: register/HI/LO mux with same-cycle write-through bypass
  logic [31:0] rd1_c;
  always_comb begin
    rd1_c = '0;
    if (bus.ra1 == HILO_ADDR)
      rd1_c = bus.hilo_sel ? hi_q : lo_q;
    else if (is_tracked(bus.ra1))
      rd1_c = gpr_q[bus.ra1[4:0]];
    if (wb_trk && (bus.wb_wa == bus.ra1))
      rd1_c = ((bus.ra1 == HILO_ADDR) && bus.hilo_sel) ? bus.wb_data_hi : bus.wb_data;
  end

  // Read port 2: identical mux for the second source operand
  logic [31:0] rd2_c;
  always_comb begin
    rd2_c = '0;
    if (bus.ra2 == HILO_ADDR)
      rd2_c = bus.hilo_sel ? hi_q : lo_q;
    else if (is_tracked(bus.ra2))
      rd2_c = gpr_q[bus.ra2[4:0]];
    if (wb_trk && (bus.wb_wa == bus.ra2))
      rd2_c = ((bus.ra2 == HILO_ADDR) && bus.hilo_sel) ? bus.wb_data_hi : bus.wb_data;
  end

  assign bus.rd1 = rd1_c;
  assign bus.rd2 = rd2_c;

  // Per-register storage and pending counters
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_reg
      logic inc;
      logic dec;
      logic we;

      // Slot 0 is never a GPR write target because address 0 is untracked
      assign we  = wb_trk && (bus.wb_wa == 6'(gi));
      assign inc = accept && (iss_slot == 5'(gi));
      assign dec = wb_trk && (wb_slot == 5'(gi)) && (cnt_q[gi] != CNT_ZERO);
      // Issue and retire on the same slot cancel out
      assign cnt_d[gi] = cnt_q[gi] + CW'(inc) - CW'(dec);

      // GPR data register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  gpr_q[gi] <= '0;
        else if (we) gpr_q[gi] <= bus.wb_data;
      end

      // Outstanding-write counter
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q[gi] <= '0;
        else        cnt_q[gi] <= cnt_d[gi];
      end
    end
  endgenerate

  // HI/LO pair written together by a single write-back to address 33
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wb_trk && (bus.wb_wa == HILO_ADDR)) begin
      hi_q <= bus.wb_data_hi;
      lo_q <= bus.wb_data;
    end
  end

  // Sticky write-back error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_err_q <= 1'b0;
    else        wb_err_q <= wb_err_d;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Table-driven bench for regfile_scoreboard: each vector drives one cycle's
// inputs, pushes its expected outputs to a scoreboard queue and compares
// them against the DUT just after the drive, before the next rising edge.
module tb_regfile_scoreboard;

  logic clk;
  logic rst_n;

  regfile_scoreboard_if bus ();

  regfile_scoreboard #(.MAX_PEND(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [5:0]  iwa;
    logic [5:0]  ra1;
    logic [5:0]  ra2;
    logic        sel;
    logic        wv;
    logic [5:0]  wwa;
    logic [31:0] wd;
    logic [31:0] wdh;
    logic        e_stall;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_err;
  } vec_t;

  typedef struct {
    string       tag;
    logic        stall;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic iv, logic [5:0] iwa, logic [5:0] ra1, logic [5:0] ra2,
                              logic sel, logic wv, logic [5:0] wwa, logic [31:0] wd,
                              logic [31:0] wdh, logic e_stall, logic [31:0] e_rd1,
                              logic [31:0] e_rd2, logic e_err);
    vec_t v;
    v.iv = iv; v.iwa = iwa; v.ra1 = ra1; v.ra2 = ra2; v.sel = sel;
    v.wv = wv; v.wwa = wwa; v.wd = wd; v.wdh = wdh;
    v.e_stall = e_stall; v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.issue_valid = v.iv;
    bus.issue_wa    = v.iwa;
    bus.ra1         = v.ra1;
    bus.ra2         = v.ra2;
    bus.hilo_sel    = v.sel;
    bus.wb_valid    = v.wv;
    bus.wb_wa       = v.wwa;
    bus.wb_data     = v.wd;
    bus.wb_data_hi  = v.wdh;
  endtask

  task automatic push_exp(vec_t v, string tag);
    exp_t e;
    e.tag = tag; e.stall = v.e_stall; e.rd1 = v.e_rd1; e.rd2 = v.e_rd2; e.err = v.e_err;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".stall"},  {31'd0, bus.stall},  {31'd0, e.stall});
    chk({e.tag, ".rd1"},    bus.rd1,             e.rd1);
    chk({e.tag, ".rd2"},    bus.rd2,             e.rd2);
    chk({e.tag, ".wb_err"}, {31'd0, bus.wb_err}, {31'd0, e.err});
    $display("%s: ra1=%0d ra2=%0d stall=%0b rd1=0x%08h rd2=0x%08h wb_err=%0b",
             e.tag, bus.ra1, bus.ra2, bus.stall, bus.rd1, bus.rd2, bus.wb_err);
  endtask

  // One cycle: drive at the falling edge, check 1ns later, edge follows
  task automatic apply(vec_t v, string tag);
    @(negedge clk);
    drive(v);
    push_exp(v, tag);
    #1;
    check_out();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Dependency tracking, bypass, HI/LO, counter saturation, error flag
    vecs.push_back(mk(1,  8,  0,  0, 0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1,  0,  8,  0, 0, 0,  0, 32'h0,        32'h0,        1, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1,  0,  8,  0, 0, 1,  8, 32'h1234,     32'h0,        0, 32'h1234,     32'h0,        0));
    vecs.push_back(mk(0,  0,  8,  0, 0, 0,  0, 32'h0,        32'h0,        0, 32'h1234,     32'h0,        0));
    vecs.push_back(mk(1, 33,  0,  0, 0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0,  0, 33,  8, 0, 1, 33, 32'hAAAA0000, 32'h5555FFFF, 0, 32'hAAAA0000, 32'h1234,     0));
    vecs.push_back(mk(0,  0, 33, 33, 0, 0,  0, 32'h0,        32'h0,        0, 32'hAAAA0000, 32'hAAAA0000, 0));
    vecs.push_back(mk(0,  0, 33, 33, 1, 0,  0, 32'h0,        32'h0,        0, 32'h5555FFFF, 32'h5555FFFF, 0));
    vecs.push_back(mk(1,  5,  0,  0, 0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1,  5,  0,  0, 0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1,  5,  0,  0, 0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1,  5,  0,  0, 0, 0,  0, 32'h0,        32'h0,        1, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1,  5,  0,  0, 0, 1,  5, 32'h55,       32'h0,        0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1,  5,  0,  0, 0, 0,  0, 32'h0,        32'h0,        1, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0,  0,  5,  0, 0, 0,  0, 32'h0,        32'h0,        0, 32'h55,       32'h0,        0));
    vecs.push_back(mk(1,  0,  5,  0, 0, 1,  5, 32'h56,       32'h0,        1, 32'h56,       32'h0,        0));
    vecs.push_back(mk(1,  0,  5,  0, 0, 1,  5, 32'h57,       32'h0,        1, 32'h57,       32'h0,        0));
    vecs.push_back(mk(1,  0,  5,  0, 0, 1,  5, 32'h58,       32'h0,        0, 32'h58,       32'h0,        0));
    vecs.push_back(mk(1,  5,  0,  0, 0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0,  0,  5,  0, 0, 1,  5, 32'h99,       32'h0,        0, 32'h99,       32'h0,        0));
    vecs.push_back(mk(0,  0,  0,  0, 0, 1,  0, 32'hFFFFFFFF, 32'h0,        0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0,  0,  0,  0, 0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0,  0, 40,  0, 0, 1, 40, 32'h77,       32'h0,        0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 40, 40,  0, 0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0,  0,  0,  9, 0, 1,  9, 32'h9,        32'h0,        0, 32'h0,        32'h9,        0));
    vecs.push_back(mk(0,  0,  0,  9, 0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        32'h9,        1));
    vecs.push_back(mk(1,  9,  0,  0, 0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1,  0,  9,  0, 0, 0,  0, 32'h0,        32'h0,        1, 32'h9,        32'h0,        1));
    vecs.push_back(mk(1,  0,  0,  9, 0, 0,  0, 32'h0,        32'h0,        1, 32'h0,        32'h9,        1));

    // Held in reset: outputs idle, bypass still works, nothing is written
    apply(mk(1, 4, 4, 33, 1, 1,  4, 32'hCAFE, 32'h0, 0, 32'hCAFE, 32'h0, 0), "rst_bypass_gpr");
    apply(mk(1, 4, 4, 33, 1, 1, 33, 32'h1,    32'h2, 0, 32'h0,    32'h2, 0), "rst_bypass_hilo");
    apply(mk(0, 0, 4, 33, 0, 0,  0, 32'h0,    32'h0, 0, 32'h0,    32'h0, 0), "rst_idle");
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted mid-cycle with a write outstanding on 7
    apply(mk(1, 7, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0,    1), "seq_issue7");
    apply(mk(1, 0, 7, 8, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0, 32'h1234, 1), "seq_raw7");
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(mk(1, 0, 7, 8, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0), "seq_async_rst");
    check_out();
    bus.ra2 = 6'd33;
    bus.hilo_sel = 1'b1;
    #1;
    push_exp(mk(1, 0, 7, 33, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0), "seq_async_rst_hi");
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1, 0, 7, 9, 0, 1, 7, 32'h70, 32'h0, 0, 32'h70, 32'h0, 0), "seq_wb7_after_rst");
    apply(mk(0, 0, 7, 0, 0, 0, 0, 32'h0,  32'h0, 0, 32'h70, 32'h0, 1), "seq_err_after_rst");

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
